// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the scan-timing and pixel-lookup stages.
// Both stages import this package so that colour width and lookup latency stay consistent.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int PIXEL_DIM_WIDTH = 10;
    localparam int COLOR_BITS      = 1;
    localparam int PIPE_LATENCY    = 2;

    // Raw (active-high) per-cycle control carried alongside the lookup pipeline.
    typedef struct packed {
        logic valid;
        logic vsync;
        logic hsync;
    } scan_ctrl_t;

endpackage

// File: rtl/vga_sync_delay.sv
// WIDTH x DEPTH shift register with synchronous active-high clear.
// A cleared stage reads as all zeros, which downstream treats as "sync inactive, not valid".
module vga_sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// Free-running raster timing generator feeding the pixel lookup stage.
// Define VGA_SCAN_BORDER_TEST_EN to paint the outermost active ring in all-ones colour.
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE_P      = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP_P          = vga_timing_pkg::H_FP,
    parameter int H_SYNC_P        = vga_timing_pkg::H_SYNC,
    parameter int H_BP_P          = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE_P      = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP_P          = vga_timing_pkg::V_FP,
    parameter int V_SYNC_P        = vga_timing_pkg::V_SYNC,
    parameter int V_BP_P          = vga_timing_pkg::V_BP,
    parameter int PIXEL_DIM_WIDTH = vga_timing_pkg::PIXEL_DIM_WIDTH,
    parameter int COLOR_BITS      = vga_timing_pkg::COLOR_BITS,
    parameter int PIPE_LATENCY    = vga_timing_pkg::PIPE_LATENCY,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       px_valid,
    output logic [PIXEL_DIM_WIDTH-1:0] px_x,
    output logic [PIXEL_DIM_WIDTH-1:0] px_y,
    input  logic [COLOR_BITS-1:0]      px_color,
    output logic [COLOR_BITS-1:0]      vga_color,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic                       vga_de,
    output logic                       frame_start
);

    localparam int W       = PIXEL_DIM_WIDTH;
    localparam int H_TOT   = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int V_TOT   = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam logic [W-1:0] H_LAST    = W'(H_TOT - 1);
    localparam logic [W-1:0] V_LAST    = W'(V_TOT - 1);
    localparam logic [W-1:0] H_VIS     = W'(H_ACTIVE_P);
    localparam logic [W-1:0] V_VIS     = W'(V_ACTIVE_P);
    localparam logic [W-1:0] HS_START  = W'(H_ACTIVE_P + H_FP_P);
    localparam logic [W-1:0] HS_END    = W'(H_ACTIVE_P + H_FP_P + H_SYNC_P - 1);
    localparam logic [W-1:0] VS_START  = W'(V_ACTIVE_P + V_FP_P);
    localparam logic [W-1:0] VS_END    = W'(V_ACTIVE_P + V_FP_P + V_SYNC_P - 1);
    localparam logic         SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [W-1:0] h_cnt;
    logic [W-1:0] v_cnt;
    scan_ctrl_t   raw_ctrl;
    scan_ctrl_t   dly_ctrl;
    logic [COLOR_BITS-1:0] color_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + W'(1);
        end else begin
            h_cnt <= h_cnt + W'(1);
        end
    end

    // Lookup handshake: px_valid has no ready; the lookup stage accepts one
    // position every clk and returns its px_color exactly PIPE_LATENCY clks later.
    assign px_x        = h_cnt;
    assign px_y        = v_cnt;
    assign px_valid    = (h_cnt < H_VIS) && (v_cnt < V_VIS) && !rst;
    assign frame_start = (h_cnt == '0) && (v_cnt == '0) && !rst;

    assign raw_ctrl.valid = px_valid;
    assign raw_ctrl.hsync = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    assign raw_ctrl.vsync = (v_cnt >= VS_START) && (v_cnt <= VS_END);

`ifdef VGA_SCAN_BORDER_TEST_EN
    logic [W-1:0] dly_x;
    logic [W-1:0] dly_y;
    logic         on_border;

    vga_sync_delay #(
        .WIDTH($bits(scan_ctrl_t) + 2 * W),
        .DEPTH(PIPE_LATENCY)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   ({h_cnt, v_cnt, raw_ctrl}),
        .q   ({dly_x, dly_y, dly_ctrl})
    );

    assign on_border = (dly_x == '0) || (dly_x == H_VIS - W'(1)) ||
                       (dly_y == '0) || (dly_y == V_VIS - W'(1));

    always_comb begin
        color_next = '0;
        if (dly_ctrl.valid) begin
            color_next = on_border ? '1 : px_color;
        end
    end
`else
    vga_sync_delay #(
        .WIDTH($bits(scan_ctrl_t)),
        .DEPTH(PIPE_LATENCY)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (raw_ctrl),
        .q   (dly_ctrl)
    );

    always_comb begin
        color_next = '0;
        if (dly_ctrl.valid) begin
            color_next = px_color;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_color <= '0;
            vga_de    <= 1'b0;
            vga_hsync <= SYNC_IDLE;
            vga_vsync <= SYNC_IDLE;
        end else begin
            vga_color <= color_next;
            vga_de    <= dly_ctrl.valid;
            vga_hsync <= dly_ctrl.hsync ^ SYNC_IDLE;
            vga_vsync <= dly_ctrl.vsync ^ SYNC_IDLE;
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a full-size 640x480 instance and a shrunk-raster instance
// (active-high syncs) run side by side against a position-from-cycle-count reference model.
module tb_vga_scan_timing;

    localparam int L = 2;

    // Shrunk raster: 32 clks per line, 19 lines, 608 clks per frame.
    localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

    localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VA = 480, D_VF = 10, D_VS = 2, D_VB = 33;

    localparam int RST_CYC = 5;
    localparam int NCYC    = RST_CYC + 3 * S_FRAME + 700;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:0] px_color = '0;

    logic       d_px_valid, d_hsync, d_vsync, d_de, d_fs;
    logic [9:0] d_px_x, d_px_y;
    logic [0:0] d_color;
    logic       s_px_valid, s_hsync, s_vsync, s_de, s_fs;
    logic [9:0] s_px_x, s_px_y;
    logic [0:0] s_color;

    vga_scan_timing u_dut_d (
        .clk         (clk),
        .rst         (rst),
        .px_valid    (d_px_valid),
        .px_x        (d_px_x),
        .px_y        (d_px_y),
        .px_color    (px_color),
        .vga_color   (d_color),
        .vga_hsync   (d_hsync),
        .vga_vsync   (d_vsync),
        .vga_de      (d_de),
        .frame_start (d_fs)
    );

    vga_scan_timing #(
        .H_ACTIVE_P(S_HA), .H_FP_P(S_HF), .H_SYNC_P(S_HS), .H_BP_P(S_HB),
        .V_ACTIVE_P(S_VA), .V_FP_P(S_VF), .V_SYNC_P(S_VS), .V_BP_P(S_VB),
        .SYNC_ACTIVE_LOW(0)
    ) u_dut_s (
        .clk         (clk),
        .rst         (rst),
        .px_valid    (s_px_valid),
        .px_x        (s_px_x),
        .px_y        (s_px_y),
        .px_color    (px_color),
        .vga_color   (s_color),
        .vga_hsync   (s_hsync),
        .vga_vsync   (s_vsync),
        .vga_de      (s_de),
        .frame_start (s_fs)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q_d[$];  // {de, color, hsync_active, vsync_active}
    logic [3:0] exp_q_s[$];
    logic [0:0] col_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: raster position and raw attributes after n clks since reset release.
    task automatic raster(input int n, input int ha, hf, hs, hb, va, vf, vs, vb,
                          output int x, output int y, output bit valid,
                          output bit hsa, output bit vsa, output bit fs);
        int ht, vt;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        x     = n % ht;
        y     = (n / ht) % vt;
        valid = (x < ha) && (y < va);
        hsa   = (x >= ha + hf) && (x < ha + hf + hs);
        vsa   = (y >= va + vf) && (y < va + vf + vs);
        fs    = (x == 0) && (y == 0);
    endtask

    function automatic logic [3:0] entry(input int x, y, ha, va, input bit valid, hsa, vsa,
                                         input logic [0:0] r);
        logic [0:0] c;
        c = valid ? r : 1'b0;
`ifdef VGA_SCAN_BORDER_TEST_EN
        if (valid && (x == 0 || x == ha - 1 || y == 0 || y == va - 1)) c = 1'b1;
`endif
        return {valid, c, hsa, vsa};
    endfunction

    // driver + per-cycle checks
    initial begin
        int n, rst_at;
        bit prev_rst;
        int sx, sy, dx, dy;
        bit sv, shs, svs, sfs, dv, dhs, dvs, dfs;
        logic [0:0] r;
        logic [3:0] e;

        n        = 0;
        prev_rst = 1'b1;
        rst_at   = RST_CYC + 2 * S_FRAME + $urandom_range(40, S_FRAME - 1);
        for (int i = 0; i < L; i++) col_q.push_back(1'b0);
        for (int i = 0; i <= L; i++) begin
            exp_q_d.push_back(4'b0);
            exp_q_s.push_back(4'b0);
        end

        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            n        = prev_rst ? 0 : n + 1;
            rst      = (t < RST_CYC) || (t == rst_at);
            prev_rst = rst;
            #1;

            raster(n, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, sx, sy, sv, shs, svs, sfs);
            raster(n, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, dx, dy, dv, dhs, dvs, dfs);

            check("s_px_x", s_px_x, sx);
            check("s_px_y", s_px_y, sy);
            check("s_px_valid", s_px_valid, sv && !rst);
            check("s_frame_start", s_fs, sfs && !rst);
            e = exp_q_s.pop_front();
            check("s_vga_de", s_de, e[3]);
            check("s_vga_color", s_color, e[2]);
            check("s_vga_hsync", s_hsync, e[1]);
            check("s_vga_vsync", s_vsync, e[0]);

            check("d_px_x", d_px_x, dx);
            check("d_px_y", d_px_y, dy);
            check("d_px_valid", d_px_valid, dv && !rst);
            check("d_frame_start", d_fs, dfs && !rst);
            e = exp_q_d.pop_front();
            check("d_vga_de", d_de, e[3]);
            check("d_vga_color", d_color, e[2]);
            check("d_vga_hsync", d_hsync, !e[1]);
            check("d_vga_vsync", d_vsync, !e[0]);

            // lookup stand-in: single lit pixel, then solid, then random colour
            if (t < RST_CYC + S_FRAME)          r = (sx == 5 && sy == 0) ? 1'b1 : 1'b0;
            else if (t < RST_CYC + 2 * S_FRAME) r = 1'b1;
            else                                r = 1'($urandom_range(0, 1));

            if (rst) begin
                foreach (exp_q_s[i]) exp_q_s[i] = 4'b0;
                foreach (exp_q_d[i]) exp_q_d[i] = 4'b0;
                exp_q_s.push_back(4'b0);
                exp_q_d.push_back(4'b0);
            end else begin
                exp_q_s.push_back(entry(sx, sy, S_HA, S_VA, sv, shs, svs, r));
                exp_q_d.push_back(entry(dx, dy, D_HA, D_VA, dv, dhs, dvs, r));
            end

            col_q.push_back(r);
            px_color = col_q.pop_front();
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
